// File: rtl/alu_seq.sv
// Multi-cycle N-bit ALU with a Run/Busy/Done handshake: single-cycle logic ops,
// bit-serial shifts and an iterative shift-add multiplier. Result and flags are registered.
module alu_seq #(
    parameter int N  = 16,
    parameter int SW = 4
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Run,
    input  logic [3:0]   op,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] result,
    output logic         Zero,
    output logic         Carry,
    output logic         Ovf,
    output logic         Illegal,
    output logic         Busy,
    output logic         Done
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SRL  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_SLTU = 4'b1010;

    // Counter is one bit wider than SW so it can hold N for the multiplier.
    localparam int            CW      = SW + 1;
    localparam logic [CW-1:0] CNT_N   = CW'(N);
    localparam logic [CW-1:0] CNT_ONE = {{SW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_MUL   = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    state_t        state_r, state_s;
    logic [3:0]    op_r, op_s;
    logic [N-1:0]  work_r, work_s;
    logic [N-1:0]  mplr_r, mplr_s;
    logic [N-1:0]  acc_r, acc_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [N-1:0]  result_r, result_s;
    logic          zero_r, zero_s;
    logic          carry_r, carry_s;
    logic          ovf_r, ovf_s;
    logic          illegal_r, illegal_s;
    logic          busy_r, busy_s;
    logic          done_r, done_s;

    logic          is_sub_s;
    logic [N-1:0]  b_eff_s;
    logic [N:0]    sum_s;
    logic [N-1:0]  sc_res_s;
    logic          sc_carry_s;
    logic          sc_ovf_s;
    logic          sc_ill_s;
    logic [SW-1:0] amt_s;
    logic          is_shift_s;
    logic [N-1:0]  shifted_s;
    logic [N-1:0]  acc_sum_s;

    // Single-cycle evaluation straight from the input operands at acceptance.
    always_comb begin
        is_sub_s   = (op == OP_SUB);
        b_eff_s    = is_sub_s ? ~B : B;
        sum_s      = {1'b0, A} + {1'b0, b_eff_s} + {{N{1'b0}}, is_sub_s};
        sc_res_s   = {N{1'b0}};
        sc_carry_s = 1'b0;
        sc_ovf_s   = 1'b0;
        sc_ill_s   = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                sc_res_s   = sum_s[N-1:0];
                sc_carry_s = sum_s[N];
                sc_ovf_s   = (A[N-1] == b_eff_s[N-1]) && (sum_s[N-1] != A[N-1]);
            end
            OP_SLT:  sc_res_s = {{(N-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: sc_res_s = {{(N-1){1'b0}}, (A < B)};
            OP_AND:  sc_res_s = A & B;
            OP_OR:   sc_res_s = A | B;
            OP_XOR:  sc_res_s = A ^ B;
            OP_SLL, OP_SRL, OP_SRA: sc_res_s = A;
            OP_MUL:  sc_res_s = {N{1'b0}};
            default: sc_ill_s = 1'b1;
        endcase
    end

    // One step of the bit-serial shifter and of the shift-add multiplier.
    always_comb begin
        case (op_r)
            OP_SLL:  shifted_s = {work_r[N-2:0], 1'b0};
            OP_SRL:  shifted_s = {1'b0, work_r[N-1:1]};
            OP_SRA:  shifted_s = {work_r[N-1], work_r[N-1:1]};
            default: shifted_s = work_r;
        endcase
        acc_sum_s = mplr_r[0] ? (acc_r + work_r) : acc_r;
    end

    // Next-state, datapath and output-register next values.
    always_comb begin
        state_s    = state_r;
        op_s       = op_r;
        work_s     = work_r;
        mplr_s     = mplr_r;
        acc_s      = acc_r;
        cnt_s      = cnt_r;
        result_s   = result_r;
        zero_s     = zero_r;
        carry_s    = carry_r;
        ovf_s      = ovf_r;
        illegal_s  = illegal_r;
        amt_s      = B[SW-1:0];
        is_shift_s = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
        case (state_r)
            ST_IDLE: begin
                if (Run) begin
                    op_s = op;
                    if (is_shift_s && (amt_s != {SW{1'b0}})) begin
                        state_s = ST_SHIFT;
                        work_s  = A;
                        cnt_s   = {1'b0, amt_s};
                    end else if (op == OP_MUL) begin
                        state_s = ST_MUL;
                        work_s  = A;
                        mplr_s  = B;
                        acc_s   = {N{1'b0}};
                        cnt_s   = CNT_N;
                    end else begin
                        state_s   = ST_DONE;
                        result_s  = sc_res_s;
                        zero_s    = (sc_res_s == {N{1'b0}});
                        carry_s   = sc_carry_s;
                        ovf_s     = sc_ovf_s;
                        illegal_s = sc_ill_s;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                work_s = shifted_s;
                cnt_s  = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    state_s   = ST_DONE;
                    result_s  = shifted_s;
                    zero_s    = (shifted_s == {N{1'b0}});
                    carry_s   = 1'b0;
                    ovf_s     = 1'b0;
                    illegal_s = 1'b0;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_MUL: begin
                acc_s  = acc_sum_s;
                work_s = {work_r[N-2:0], 1'b0};
                mplr_s = {1'b0, mplr_r[N-1:1]};
                cnt_s  = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    state_s   = ST_DONE;
                    result_s  = acc_sum_s;
                    zero_s    = (acc_sum_s == {N{1'b0}});
                    carry_s   = 1'b0;
                    ovf_s     = 1'b0;
                    illegal_s = 1'b0;
                end else begin
                    state_s = ST_MUL;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
        busy_s = (state_s != ST_IDLE);
        done_s = (state_s == ST_DONE);
    end

    // State, shadow and output registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r   <= ST_IDLE;
            op_r      <= 4'b0000;
            work_r    <= {N{1'b0}};
            mplr_r    <= {N{1'b0}};
            acc_r     <= {N{1'b0}};
            cnt_r     <= {CW{1'b0}};
            result_r  <= {N{1'b0}};
            zero_r    <= 1'b1;
            carry_r   <= 1'b0;
            ovf_r     <= 1'b0;
            illegal_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            op_r      <= op_s;
            work_r    <= work_s;
            mplr_r    <= mplr_s;
            acc_r     <= acc_s;
            cnt_r     <= cnt_s;
            result_r  <= result_s;
            zero_r    <= zero_s;
            carry_r   <= carry_s;
            ovf_r     <= ovf_s;
            illegal_r <= illegal_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
        end
    end

    assign result  = result_r;
    assign Zero    = zero_r;
    assign Carry   = carry_r;
    assign Ovf     = ovf_r;
    assign Illegal = illegal_r;
    assign Busy    = busy_r;
    assign Done    = done_r;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (N=16): directed vector table, handshake corner
// sequences and randomized operations against a plain-arithmetic reference model.
module tb_alu_seq;

    logic        Clock;
    logic        Reset;
    logic        Run;
    logic [3:0]  op;
    logic [15:0] A;
    logic [15:0] B;
    logic [15:0] result;
    logic        Zero, Carry, Ovf, Illegal, Busy, Done;

    int checks   = 0;
    int failures = 0;

    alu_seq #(.N(16), .SW(4)) dut (
        .Clock(Clock), .Reset(Reset), .Run(Run), .op(op), .A(A), .B(B),
        .result(result), .Zero(Zero), .Carry(Carry), .Ovf(Ovf),
        .Illegal(Illegal), .Busy(Busy), .Done(Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        z;
        logic        c;
        logic        v;
        logic        il;
        int          lat;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: computes results from the arithmetic definition of each op.
    task automatic model(input logic [3:0] mop, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] res, output logic z, output logic c,
                         output logic v, output logic il, output int lat);
        int sa, sb, s;
        int amt;
        logic signed [15:0] sra_v;
        logic [31:0] prod;
        sa  = $signed(a);
        sb  = $signed(b);
        amt = int'(b[3:0]);
        res = 16'h0000; c = 1'b0; v = 1'b0; il = 1'b0; lat = 1;
        case (mop)
            4'd0: begin
                res = a + b;
                c   = (int'(a) + int'(b)) > 65535;
                s   = sa + sb;
                v   = (s > 32767) || (s < -32768);
            end
            4'd1: begin
                res = a - b;
                c   = (a >= b);
                s   = sa - sb;
                v   = (s > 32767) || (s < -32768);
            end
            4'd2:  res = (sa < sb) ? 16'd1 : 16'd0;
            4'd10: res = (a < b) ? 16'd1 : 16'd0;
            4'd3:  begin res = a << amt; lat = amt + 1; end
            4'd4:  begin res = a >> amt; lat = amt + 1; end
            4'd9:  begin sra_v = $signed(a) >>> amt; res = sra_v; lat = amt + 1; end
            4'd5:  res = a & b;
            4'd6:  res = a | b;
            4'd7:  res = a ^ b;
            4'd8:  begin prod = {16'h0000, a} * {16'h0000, b}; res = prod[15:0]; lat = 17; end
            default: il = 1'b1;
        endcase
        z = (res == 16'h0000);
    endtask

    // Issue one op from IDLE (called at a negedge) and check it through to IDLE again.
    task automatic run_op(input string name, input logic [3:0] o, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] er, input logic ez,
                          input logic ec, input logic ev, input logic eil, input int elat);
        int n, busy_n;
        op = o; A = a; B = b; Run = 1'b1;
        @(posedge Clock);
        #1;
        Run = 1'b0;
        op = 4'($urandom_range(0, 15)); A = 16'($urandom); B = 16'($urandom);
        n = 0; busy_n = 0;
        do begin
            @(negedge Clock);
            n++;
            if (Busy) busy_n++;
        end while (!Done && n < 40);
        chk({name, " latency"}, 32'(n), 32'(elat));
        chk({name, " busy_cycles"}, 32'(busy_n), 32'(elat));
        chk({name, " result"}, {16'h0000, result}, {16'h0000, er});
        chk({name, " flags zcvi"}, {28'h0, Zero, Carry, Ovf, Illegal}, {28'h0, ez, ec, ev, eil});
        @(negedge Clock);
        chk({name, " idle busy/done"}, {30'h0, Busy, Done}, 32'h0);
    endtask

    initial begin
        logic [15:0] mr;
        logic mz, mc, mv, mil;
        int mlat, n, dcount;

        tbl[0]  = '{4'h0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        tbl[1]  = '{4'h1, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1};
        tbl[2]  = '{4'h9, 16'h8000, 16'h0004, 16'hF800, 1'b0, 1'b0, 1'b0, 1'b0, 5};
        tbl[3]  = '{4'h4, 16'h8000, 16'h0004, 16'h0800, 1'b0, 1'b0, 1'b0, 1'b0, 5};
        tbl[4]  = '{4'h3, 16'h8000, 16'h0010, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[5]  = '{4'h8, 16'h0123, 16'h0045, 16'h4E6F, 1'b0, 1'b0, 1'b0, 1'b0, 17};
        tbl[6]  = '{4'h8, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 17};
        tbl[7]  = '{4'h2, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[8]  = '{4'hA, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        tbl[9]  = '{4'hC, 16'h1234, 16'h5678, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1};
        tbl[10] = '{4'h7, 16'hAAAA, 16'hFFFF, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[11] = '{4'h1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[12] = '{4'h1, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b1, 1'b0, 1};
        tbl[13] = '{4'h3, 16'h0001, 16'h000F, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b0, 16};
        tbl[14] = '{4'h0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1};

        Reset = 1'b1; Run = 1'b0; op = 4'h0; A = 16'h0; B = 16'h0;
        repeat (3) @(negedge Clock);
        chk("reset outputs", {result, 10'h0, Zero, Carry, Ovf, Illegal, Busy, Done},
            {16'h0000, 10'h0, 6'b100000});
        Reset = 1'b0;
        @(negedge Clock);

        for (int i = 0; i < 15; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res,
                   tbl[i].z, tbl[i].c, tbl[i].v, tbl[i].il, tbl[i].lat);
        end

        // Reset during a multiply abandons it with no Done.
        run_op("pre_reset add", 4'h0, 16'h0002, 16'h0003, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        op = 4'h8; A = 16'h0003; B = 16'h0005; Run = 1'b1;
        @(negedge Clock);
        Run = 1'b0;
        Reset = 1'b1;
        @(negedge Clock);
        chk("mid-mul reset outputs", {result, 10'h0, Zero, Carry, Ovf, Illegal, Busy, Done},
            {16'h0000, 10'h0, 6'b100000});
        Reset = 1'b0;
        dcount = 0;
        repeat (25) begin
            @(negedge Clock);
            if (Done || Busy) dcount++;
        end
        chk("no done after reset", 32'(dcount), 32'd0);

        // Run held high through a multiply; operand change at E3 must not matter.
        op = 4'h8; A = 16'h0123; B = 16'h0045; Run = 1'b1;
        n = 0;
        do begin
            @(negedge Clock);
            n++;
            if (n == 2) begin A = 16'hFFFF; B = 16'h0000; end
        end while (!Done && n < 40);
        chk("held-run mul latency", 32'(n), 32'd17);
        chk("held-run mul result", {16'h0, result}, 32'h4E6F);
        op = 4'h0; A = 16'h0002; B = 16'h0003;
        @(negedge Clock);
        chk("held-run idle gap", {30'h0, Busy, Done}, 32'h0);
        @(negedge Clock);
        chk("held-run reaccept done", {31'h0, Done}, 32'h1);
        chk("held-run reaccept result", {16'h0, result}, 32'h0005);
        Run = 1'b0;
        @(negedge Clock);
        @(negedge Clock);

        for (int k = 0; k < 120; k++) begin
            logic [3:0]  ro;
            logic [15:0] ra, rb;
            ro = 4'($urandom_range(0, 15));
            ra = 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            model(ro, ra, rb, mr, mz, mc, mv, mil, mlat);
            run_op($sformatf("rnd%0d op%0h", k, ro), ro, ra, rb, mr, mz, mc, mv, mil, mlat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised multi-cycle ALU; next generation of the 16-bit datapath ALU.
- Sits between the register file and the bus mux in the processor datapath, driven by the control FSM.
- Adds to the existing set: OR/XOR, arithmetic shift right, unsigned compare, and an iterative shift-add multiplier.
- Uses a Run/Busy/Done handshake and registered result and flags, so the controller can stall on multi-cycle operations.

Parameters:
- N, 16, operand/result width in bits (N >= 4, power of two).
- SW, 4, shift-amount width; must equal log2(N). Only B[SW-1:0] is used for shifts.

Ports:
- Clock  in  1  single system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Run  in  1  request; sampled only in IDLE.
- op  in  4  operation code, captured with Run.
- A  in  N  operand A, captured with Run.
- B  in  N  operand B / shift amount, captured with Run.
- result  out  N  registered result; holds until the next Done.
- Zero  out  1  registered; 1 when result == 0.
- Carry  out  1  registered; carry-out (add) or no-borrow (sub); 0 for other ops.
- Ovf  out  1  registered; signed overflow for add/sub; 0 for other ops.
- Illegal  out  1  registered; 1 when the captured op is unassigned.
- Busy  out  1  1 from the accepting edge until the Done cycle, inclusive.
- Done  out  1  one-cycle pulse; result and flags are valid when Done = 1.

Behaviour:
- Opcodes:
  - 0000 add, 0001 sub, 0010 slt (signed), 0011 sll, 0100 srl, 0101 and, 0110 or, 0111 xor, 1000 mul, 1001 sra, 1010 sltu.
  - 1011-1111 are illegal.
- Reset: state IDLE; result = 0, Zero = 1, Carry = Ovf = Illegal = Busy = Done = 0; counter and shadow registers cleared.
- Reset mid-operation: the operation is abandoned, no Done is issued, and all outputs take their reset values on that edge.
- States:
  - IDLE -> DONE on edge E0 (Run = 1) for single-cycle ops, illegal ops, and shifts with amount 0.
  - IDLE -> SHIFT for shifts with amount s > 0.
  - IDLE -> MUL for mul.
  - SHIFT -> DONE on the edge where the count reaches 0.
  - MUL -> DONE after N iterations.
  - DONE -> IDLE unconditionally.
- Latency, counted from acceptance edge E0:
  - Single-cycle ops: Done is high in the cycle after E0.
  - Shift by s > 0: Done is high after edge E(s).
  - mul: Done is high after edge E(N).
- Throughput: Run is accepted only in IDLE, so back-to-back single-cycle ops take 2 cycles each. Run in any other state is ignored and is not queued.
- Operand isolation: op, A and B are captured at E0. Later changes have no effect until the next acceptance.
- add/sub:
  - Computed at N+1 bits; Carry = bit N.
  - Ovf = (sign A == sign B') and (sign result != sign A), where B' = B for add and ~B for sub.
- slt/sltu: result = 1 (zero-extended to N) when A < B under signed / unsigned compare, else 0.
- Shifts:
  - One bit position per cycle; amount = B[SW-1:0], so results wrap modulo N.
  - srl fills with 0; sra replicates A[N-1].
- mul:
  - Shift-add. Load acc = 0, mcand = A, mplr = B.
  - Each cycle: if mplr[0], acc += mcand; then mcand <<= 1 and mplr >>= 1.
  - result = low N bits of the product (signed/unsigned agnostic).
- Illegal op: result = 0, Zero = 1, Illegal = 1; Done still pulses.
- Flags update only on the edge that enters DONE; between operations they hold.
- Zero is derived from the value being written into result.

Test Plan:
- Reset while in MUL (A=3, B=5, reset at E2) -> next cycle: result=0, Busy=0, Done=0, state IDLE; no Done pulse follows.
- add A=0x7FFF, B=0x0001 (N=16) -> Done in cycle after E0; result=0x8000, Ovf=1, Carry=0, Zero=0. Then sub A=5, B=5 -> result=0, Zero=1, Carry=1.
- sra A=0x8000, B=0x0004 -> Done after E4; result=0xF800; Busy high 5 cycles. srl same operands -> 0x0800. sll with B=0x0010 (amount 0) -> result=0x8000 after 1 cycle.
- mul A=0x0123, B=0x0045 -> Done after E16; result=0x4E6F. mul A=0xFFFF, B=0xFFFF -> result=0x0001.
- slt A=0xFFFF, B=0x0001 -> result=1; sltu same operands -> result=0. Illegal op 1100 -> result=0, Illegal=1, Done pulses.
- Run held high during a mul, and A changed at E3 -> no re-acceptance until IDLE, result unaffected. Run still high in IDLE -> a new op is accepted on the following edge.
